// File: rtl/gps_ce_monitor.sv
// -----------------------------------------------------------------------------
// gps_ce_monitor
//
// Watches the slow-clock event stream produced by the GPS clock generator and
// verifies that events arrive every DIV fast-clock cycles. After LOCK_CNT
// consecutive correct periods the stream is declared locked. Wrong spacing or
// a missing event (no event within 2*DIV cycles) raises a one-cycle error
// pulse and bumps a saturating error counter.
//
// Parameters:
//   DIV       expected cycles between events (2..127)
//   LOCK_CNT  consecutive matching periods required for lock (1..15)
//
// Ports:
//   sys_clk_50   in   sole clock, all state on its rising edge
//   gps_rst_n    in   asynchronous active-low reset
//   ce_in        in   event source (pulse, or square wave in toggle mode)
//   clr_err      in   synchronous clear of err_cnt
//   locked       out  event stream verified at DIV cycles
//   err_pulse    out  one-cycle pulse per period error or timeout
//   err_cnt      out  saturating error count
//   period_last  out  most recent measured event-to-event period
//
// Build option:
//   GPS_CE_MON_TOGGLE_EN  when defined, ce_in is a divided square wave and an
//                         event is any edge of it; otherwise ce_in is a
//                         one-cycle enable pulse.
// -----------------------------------------------------------------------------
module gps_ce_monitor #(
    parameter int DIV      = 5,
    parameter int LOCK_CNT = 4
) (
    input  logic       sys_clk_50,
    input  logic       gps_rst_n,
    input  logic       ce_in,
    input  logic       clr_err,
    output logic       locked,
    output logic       err_pulse,
    output logic [7:0] err_cnt,
    output logic [7:0] period_last
);

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    localparam logic [7:0] DIV_C  = 8'(DIV);
    localparam logic [7:0] TMO_C  = 8'(2 * DIV);
    localparam logic [3:0] LOCK_C = 4'(LOCK_CNT);

    state_t     state_r;
    logic [7:0] cyc_cnt_r;   // 0 = no reference event yet
    logic [3:0] match_r;
    logic       event_s;
    logic       mismatch_s;
    logic       timeout_s;
    logic       err_s;

`ifdef GPS_CE_MON_TOGGLE_EN
    logic ce_d_r;

    // One-cycle delayed copy of ce_in for edge detection; starts at 0 so the
    // first rising level after reset counts as an edge.
    always_ff @(posedge sys_clk_50 or negedge gps_rst_n) begin
        if (!gps_rst_n) begin
            ce_d_r <= 1'b0;
        end else begin
            ce_d_r <= ce_in;
        end
    end

    assign event_s = ce_in ^ ce_d_r;
`else
    assign event_s = ce_in;
`endif

    // Period check and timeout decode; neither applies while searching.
    always_comb begin
        mismatch_s = 1'b0;
        timeout_s  = 1'b0;
        if (state_r == ST_SEARCH) begin
            mismatch_s = 1'b0;
            timeout_s  = 1'b0;
        end else if (event_s) begin
            // cyc_cnt is always nonzero outside SEARCH, so this is a real period
            mismatch_s = (cyc_cnt_r != DIV_C);
            timeout_s  = 1'b0;
        end else begin
            mismatch_s = 1'b0;
            timeout_s  = (cyc_cnt_r == TMO_C);
        end
    end

    assign err_s = mismatch_s | timeout_s;

    // Period counter, lock state machine and all registered outputs.
    always_ff @(posedge sys_clk_50 or negedge gps_rst_n) begin
        if (!gps_rst_n) begin
            state_r     <= ST_SEARCH;
            cyc_cnt_r   <= 8'd0;
            match_r     <= 4'd0;
            locked      <= 1'b0;
            err_pulse   <= 1'b0;
            err_cnt     <= 8'd0;
            period_last <= 8'd0;
        end else begin
            err_pulse <= err_s;

            // A clear wins over history but not over an error in the same cycle.
            if (clr_err) begin
                err_cnt <= err_s ? 8'd1 : 8'd0;
            end else if (err_s && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end else begin
                err_cnt <= err_cnt;
            end

            if (event_s && (cyc_cnt_r != 8'd0)) begin
                period_last <= cyc_cnt_r;
            end else begin
                period_last <= period_last;
            end

            // Every event becomes the new reference, including mismatching ones.
            if (event_s) begin
                cyc_cnt_r <= 8'd1;
            end else if (timeout_s) begin
                cyc_cnt_r <= 8'd0;
            end else if ((cyc_cnt_r != 8'd0) && (cyc_cnt_r != 8'hFF)) begin
                cyc_cnt_r <= cyc_cnt_r + 8'd1;
            end else begin
                cyc_cnt_r <= cyc_cnt_r;
            end

            case (state_r)
                ST_SEARCH: begin
                    if (event_s) begin
                        state_r <= ST_ACQUIRE;
                        match_r <= 4'd0;
                        locked  <= 1'b0;
                    end else begin
                        state_r <= ST_SEARCH;
                        match_r <= 4'd0;
                        locked  <= 1'b0;
                    end
                end
                ST_ACQUIRE: begin
                    if (timeout_s) begin
                        state_r <= ST_SEARCH;
                        match_r <= 4'd0;
                        locked  <= 1'b0;
                    end else if (mismatch_s) begin
                        state_r <= ST_ACQUIRE;
                        match_r <= 4'd0;
                        locked  <= 1'b0;
                    end else if (event_s) begin
                        match_r <= match_r + 4'd1;
                        if ((match_r + 4'd1) == LOCK_C) begin
                            state_r <= ST_LOCKED;
                            locked  <= 1'b1;
                        end else begin
                            state_r <= ST_ACQUIRE;
                            locked  <= 1'b0;
                        end
                    end else begin
                        state_r <= ST_ACQUIRE;
                        match_r <= match_r;
                        locked  <= 1'b0;
                    end
                end
                ST_LOCKED: begin
                    if (timeout_s) begin
                        state_r <= ST_SEARCH;
                        match_r <= 4'd0;
                        locked  <= 1'b0;
                    end else if (mismatch_s) begin
                        state_r <= ST_ACQUIRE;
                        match_r <= 4'd0;
                        locked  <= 1'b0;
                    end else begin
                        state_r <= ST_LOCKED;
                        match_r <= match_r;
                        locked  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_SEARCH;
                    match_r <= 4'd0;
                    locked  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gps_ce_monitor.sv
// -----------------------------------------------------------------------------
// tb_gps_ce_monitor
//
// Directed stimulus with hand-computed expectations for gps_ce_monitor at
// DIV=5, LOCK_CNT=4. The stimulus process pushes expected state snapshots and
// expected error pulses into queues; a monitor process samples on the falling
// edge, pops an error entry whenever err_pulse is high and checks every
// pending snapshot. The same scenario runs in pulse and toggle builds: an
// "event" tick emits a pulse or flips the square-wave level.
// -----------------------------------------------------------------------------
module tb_gps_ce_monitor;

    localparam int DIV      = 5;
    localparam int LOCK_CNT = 4;

    logic       sys_clk_50 = 1'b0;
    logic       gps_rst_n  = 1'b0;
    logic       ce_in      = 1'b0;
    logic       clr_err    = 1'b0;
    logic       locked;
    logic       err_pulse;
    logic [7:0] err_cnt;
    logic [7:0] period_last;

    gps_ce_monitor #(
        .DIV      (DIV),
        .LOCK_CNT (LOCK_CNT)
    ) dut (
        .sys_clk_50  (sys_clk_50),
        .gps_rst_n   (gps_rst_n),
        .ce_in       (ce_in),
        .clr_err     (clr_err),
        .locked      (locked),
        .err_pulse   (err_pulse),
        .err_cnt     (err_cnt),
        .period_last (period_last)
    );

    always #5 sys_clk_50 = ~sys_clk_50;

    typedef struct packed {
        logic       lk;
        logic [7:0] ec;
        logic [7:0] pl;
    } snap_t;

    typedef struct packed {
        logic [7:0] ec;
        logic [7:0] pl;
    } err_t;

    snap_t snap_q[$];
    string snap_name_q[$];
    err_t  err_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    logic lvl = 1'b0;   // square-wave level in toggle builds

    // One stimulus cycle: inputs change 1 time unit after the rising edge, so
    // outputs seen in this window reflect the inputs of the previous tick.
    task automatic tick(input logic ev, input logic clr);
        @(posedge sys_clk_50);
        #1;
`ifdef GPS_CE_MON_TOGGLE_EN
        if (ev) lvl = ~lvl;
        ce_in = lvl;
`else
        ce_in = ev;
`endif
        clr_err = clr;
    endtask

    task automatic period(input int n);
        tick(1'b1, 1'b0);
        repeat (n - 1) tick(1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 1'b0);
    endtask

    task automatic expect_state(input string name, input logic lk,
                                input logic [7:0] ec, input logic [7:0] pl);
        snap_t s;
        s.lk = lk;
        s.ec = ec;
        s.pl = pl;
        snap_q.push_back(s);
        snap_name_q.push_back(name);
    endtask

    task automatic expect_err(input logic [7:0] ec, input logic [7:0] pl);
        err_t e;
        e.ec = ec;
        e.pl = pl;
        err_q.push_back(e);
    endtask

    // Monitor: compares DUT outputs against queued expectations.
    initial begin
        err_t  e;
        snap_t s;
        string nm;
        forever begin
            @(negedge sys_clk_50);
            if (err_pulse === 1'b1) begin
                n_cmp++;
                if (err_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL err_pulse_unexpected: err_cnt=%0d period_last=%0d, required no pulse",
                             err_cnt, period_last);
                end else begin
                    e = err_q.pop_front();
                    if (err_cnt !== e.ec || period_last !== e.pl) begin
                        n_bad++;
                        $display("FAIL err_pulse_values: err_cnt=%0d period_last=%0d, required err_cnt=%0d period_last=%0d",
                                 err_cnt, period_last, e.ec, e.pl);
                    end
                end
            end
            while (snap_q.size() > 0) begin
                s  = snap_q.pop_front();
                nm = snap_name_q.pop_front();
                n_cmp++;
                if (locked !== s.lk || err_cnt !== s.ec || period_last !== s.pl) begin
                    n_bad++;
                    $display("FAIL %s: locked=%0b err_cnt=%0d period_last=%0d, required locked=%0b err_cnt=%0d period_last=%0d",
                             nm, locked, err_cnt, period_last, s.lk, s.ec, s.pl);
                end
            end
        end
    end

    // Stimulus.
    initial begin
        int v;

        // Reset state
        repeat (2) @(posedge sys_clk_50);
        #1;
        expect_state("reset_state", 1'b0, 8'd0, 8'd0);
        tick(1'b0, 1'b0);
        gps_rst_n = 1'b1;
        idle(2);

        // Lock: fifth event at spacing 5 locks on the following cycle
        repeat (4) period(5);
        tick(1'b1, 1'b0);
        expect_state("lock_pre", 1'b0, 8'd0, 8'd5);
        tick(1'b0, 1'b0);
        expect_state("lock_rise", 1'b1, 8'd0, 8'd5);
        idle(3);

        // One period of 6 while locked, then relock after 4 good periods
        period(6);
        tick(1'b1, 1'b0);
        expect_state("locked_before_err", 1'b1, 8'd0, 8'd5);
        expect_err(8'd1, 8'd6);
        tick(1'b0, 1'b0);
        expect_state("after_spacing6", 1'b0, 8'd1, 8'd6);
        idle(3);
        repeat (3) period(5);
        tick(1'b1, 1'b0);
        expect_state("relock_pre", 1'b0, 8'd1, 8'd5);
        tick(1'b0, 1'b0);
        expect_state("relock", 1'b1, 8'd1, 8'd5);
        idle(3);

        // Timeout: input stays quiet, error when the count reaches 10
        idle(5);
        expect_err(8'd2, 8'd5);
        tick(1'b0, 1'b0);
        expect_state("timeout_pre", 1'b1, 8'd1, 8'd5);
        tick(1'b0, 1'b0);
        expect_state("timeout", 1'b0, 8'd2, 8'd5);
        idle(30);
        expect_state("search_quiet", 1'b0, 8'd2, 8'd5);

        // 300 back-to-back mismatches saturate the counter
        for (int k = 1; k <= 300; k++) begin
            v = 2 + k;
            if (v > 255) v = 255;
            expect_err(8'(v), 8'd1);
        end
        repeat (301) tick(1'b1, 1'b0);

        // Clear coincident with an error, then a plain clear
        expect_err(8'd1, 8'd1);
        tick(1'b1, 1'b1);
        expect_state("saturated", 1'b0, 8'd255, 8'd1);
        tick(1'b0, 1'b1);
        expect_state("clr_with_err", 1'b0, 8'd1, 8'd1);
        tick(1'b0, 1'b0);
        expect_state("clr_only", 1'b0, 8'd0, 8'd1);
        idle(2);
        repeat (4) period(5);
        tick(1'b1, 1'b0);
        expect_state("relock2", 1'b1, 8'd0, 8'd5);
        idle(2);

        // Asynchronous reset mid-stream, then a fresh acquisition
        gps_rst_n = 1'b0;
        lvl       = 1'b0;
        ce_in     = 1'b0;
        expect_state("async_reset", 1'b0, 8'd0, 8'd0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        gps_rst_n = 1'b1;
        repeat (4) period(5);
        tick(1'b1, 1'b0);
        expect_state("post_reset_pre", 1'b0, 8'd0, 8'd5);
        tick(1'b0, 1'b0);
        expect_state("post_reset_lock", 1'b1, 8'd0, 8'd5);
        idle(2);

        n_cmp++;
        if (err_q.size() != 0) begin
            n_bad++;
            $display("FAIL missing_err_pulses: outstanding=%0d, required 0", err_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
